// File: rtl/modmul_pkg.sv
// Shared definitions for the 256-bit modular multiplier and its result collector.
package modmul_pkg;

  localparam int MODMUL_WIDTH = 256;
  localparam int MODMUL_SEQ_W = 16;

  typedef logic [MODMUL_WIDTH-1:0] modmul_word_t;

endpackage

// File: rtl/modmul_sync_fifo.sv
// Synchronous FIFO with a registered output stage: a push is visible on rdata_o one cycle later.
module modmul_sync_fifo #(
  parameter int WIDTH = 272,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       rvalid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       push_ok_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             full, empty, pop_ok, push_ok;

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign pop_ok  = pop_i & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    rvalid_d = (wr_ptr_d != rd_ptr_d);
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      // New head is the entry being written this cycle when the FIFO was drained to it.
      if (rd_ptr_d == wr_ptr_q) rdata_d = wdata_i;
      else                      rdata_d = mem_q[rd_ptr_d[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign push_ok_o  = push_ok;
  assign overflow_o = push_i & full & ~pop_ok;

endmodule

// File: rtl/modmul_result_collector.sv
// Buffers multiplier products, tags them with a sequence number and meters issue credits
// so the FIFO cannot overflow while the multiplier pipeline has no backpressure.
module modmul_result_collector
  import modmul_pkg::*;
#(
  parameter int WIDTH = MODMUL_WIDTH,
  parameter int DEPTH = 8,
  parameter int SEQ_W = MODMUL_SEQ_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     mul_out_valid,
  input  logic [WIDTH-1:0]         mul_q,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [SEQ_W-1:0]         m_seq,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_overflow,
  output logic                     err_underflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = WIDTH + SEQ_W;

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] fifo_rdata;
  logic             fifo_rvalid, fifo_push_ok, fifo_overflow;
  logic [CNT_W:0]   credits_used;
  logic             issue_fire, ret_ok, pop;

  // Every issued operand pair owns a slot until its product leaves the FIFO.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue_ready  = (credits_used < (CNT_W+1)'(DEPTH));
  assign issue_fire   = issue_valid & issue_ready;
  assign ret_ok       = mul_out_valid & (inflight_q != '0);
  assign pop          = fifo_rvalid & m_ready;

  always_comb begin
    inflight_d = inflight_q;
    case ({issue_fire, ret_ok})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    seq_d     = seq_q + SEQ_W'(fifo_push_ok);
    err_ovf_d = err_ovf_q | fifo_overflow;
    err_unf_d = err_unf_q | (mul_out_valid & (inflight_q == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
      seq_q      <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      seq_q      <= seq_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  modmul_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .srst_i     (reset),
    .push_i     (mul_out_valid),
    .wdata_i    ({mul_q, seq_q}),
    .pop_i      (pop),
    .rdata_o    (fifo_rdata),
    .rvalid_o   (fifo_rvalid),
    .count_o    (fifo_count),
    .push_ok_o  (fifo_push_ok),
    .overflow_o (fifo_overflow)
  );

  assign m_valid       = fifo_rvalid;
  assign m_data        = fifo_rdata[ENT_W-1:SEQ_W];
  assign m_seq         = fifo_rdata[SEQ_W-1:0];
  assign inflight      = inflight_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule
